conv_cfg_ctrl: RTL

Configuration sequencer and stream gate for the 1D convolution block. It accepts a byte-serial parameter stream, assembles each byte group into a full weight or bias word, and issues the write sequence into the convolution parameter memory. It reaches that memory only through the conv block's `rd_en_i`, `wr_en_i`, bank, address and data ports. The feature stream is held off while loading, and a load starts only after every in-flight frame has drained, so no frame is ever computed with mixed parameter sets.

---
 rtl/conv_cfg_ctrl_if.sv | 58 +++++
 rtl/conv_cfg_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/conv_cfg_ctrl_if.sv
// Signal bundle around conv_cfg_ctrl: parameter byte stream, feature pass-through,
// conv output monitor and parameter-memory port. master = controller, slave = environment.
interface conv_cfg_ctrl_if #(
  parameter int VECTOR_LEN  = 13,
  parameter int NUM_FILTERS = 8
);
  localparam int VECTOR_BW = 8 * VECTOR_LEN;
  localparam int ADDR_BW   = $clog2(NUM_FILTERS);

  logic                 cfg_start_i;
  logic [7:0]           cfg_data_i;
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [VECTOR_BW-1:0] s_data_i;
  logic                 s_valid_i;
  logic                 s_last_i;
  logic                 s_ready_o;
  logic [VECTOR_BW-1:0] m_data_o;
  logic                 m_valid_o;
  logic                 m_last_o;
  logic                 m_ready_i;
  logic                 conv_valid_i;
  logic                 conv_last_i;
  logic                 conv_ready_i;
  logic                 mem_rd_en_o;
  logic                 mem_wr_en_o;
  logic [1:0]           mem_bank_o;
  logic [ADDR_BW-1:0]   mem_addr_o;
  logic [VECTOR_BW-1:0] mem_wr_data_o;
  logic [VECTOR_BW-1:0] mem_rd_data_i;

  modport master (
    input  cfg_start_i, cfg_data_i, cfg_valid_i,
    output cfg_ready_o, busy_o, done_o, err_o,
    input  s_data_i, s_valid_i, s_last_i,
    output s_ready_o,
    output m_data_o, m_valid_o, m_last_o,
    input  m_ready_i,
    input  conv_valid_i, conv_last_i, conv_ready_i,
    output mem_rd_en_o, mem_wr_en_o, mem_bank_o, mem_addr_o, mem_wr_data_o,
    input  mem_rd_data_i
  );

  modport slave (
    output cfg_start_i, cfg_data_i, cfg_valid_i,
    input  cfg_ready_o, busy_o, done_o, err_o,
    output s_data_i, s_valid_i, s_last_i,
    input  s_ready_o,
    input  m_data_o, m_valid_o, m_last_o,
    output m_ready_i,
    output conv_valid_i, conv_last_i, conv_ready_i,
    input  mem_rd_en_o, mem_wr_en_o, mem_bank_o, mem_addr_o, mem_wr_data_o,
    output mem_rd_data_i
  );
endinterface

// File: rtl/conv_cfg_ctrl.sv
// Conv parameter loader: drains in-flight frames, packs bytes into words, writes banks 0..3.
// Zero-latency gated feature pass-through; CONV_CFG_READBACK_EN adds READ/CHECK verify.
module conv_cfg_ctrl #(
  parameter int VECTOR_LEN      = 13,
  parameter int NUM_FILTERS     = 8,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  conv_cfg_ctrl_if.master bus
);
  localparam int VECTOR_BW = 8 * VECTOR_LEN;
  localparam int ADDR_BW   = $clog2(NUM_FILTERS);
  localparam int CNT_BW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int BYTE_BW   = $clog2(VECTOR_LEN);

  localparam logic [BYTE_BW-1:0] LAST_BYTE = BYTE_BW'(VECTOR_LEN - 1);
  localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(NUM_FILTERS - 1);
  localparam logic [CNT_BW-1:0]  MAX_CNT   = CNT_BW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE, DRAIN, LOAD, WRITE
`ifdef CONV_CFG_READBACK_EN
    , READ, CHECK
`endif
  } state_t;

  state_t               state;
  logic [CNT_BW-1:0]    outstanding;
  logic                 frame_open;
  logic [BYTE_BW-1:0]   byte_cnt;
  logic                 cfg_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 wr_en_q;
  logic [1:0]           bank_q;
  logic [ADDR_BW-1:0]   addr_q;
  logic [VECTOR_BW-1:0] wr_data_q;

  logic gate, s_ready, s_fire, s_last_fire, c_last_fire, cfg_fire, last_word, step;

  always_comb begin
    gate = 1'b0;
    case (state)
      IDLE:    gate = frame_open || (outstanding != MAX_CNT);
      DRAIN:   gate = frame_open;
      default: gate = 1'b0;
    endcase
  end

  assign s_ready        = bus.m_ready_i & gate;
  assign bus.s_ready_o  = s_ready;
  assign bus.m_valid_o  = bus.s_valid_i & gate;
  assign bus.m_data_o   = bus.s_data_i;
  assign bus.m_last_o   = bus.s_last_i;

  assign s_fire      = bus.s_valid_i & s_ready;
  assign s_last_fire = s_fire & bus.s_last_i;
  assign c_last_fire = bus.conv_valid_i & bus.conv_ready_i & bus.conv_last_i;
  assign cfg_fire    = bus.cfg_valid_i & cfg_ready_q;
  assign last_word   = (bank_q == 2'd3) && (addr_q == LAST_ADDR);

  // The word pointer advances after the write, or after the verify when readback is built in.
`ifdef CONV_CFG_READBACK_EN
  assign step = (state == CHECK);
`else
  assign step = (state == WRITE);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      outstanding <= '0;
      frame_open  <= 1'b0;
    end else begin
      if (s_fire) frame_open <= !bus.s_last_i;
      if (s_last_fire && !c_last_fire)
        outstanding <= outstanding + CNT_BW'(1);
      else if (c_last_fire && !s_last_fire && outstanding != '0)
        outstanding <= outstanding - CNT_BW'(1);
    end
  end

`ifdef CONV_CFG_READBACK_EN
  logic rd_en_q;
  logic err_q;
  assign bus.mem_rd_en_o = rd_en_q;
  assign bus.err_o       = err_q;
`else
  logic unused_rd_data;
  assign unused_rd_data  = ^bus.mem_rd_data_i;
  assign bus.mem_rd_en_o = 1'b0;
  assign bus.err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      bank_q      <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
`ifdef CONV_CFG_READBACK_EN
      rd_en_q     <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.cfg_start_i) begin
          state    <= DRAIN;
          busy_q   <= 1'b1;
          bank_q   <= '0;
          addr_q   <= '0;
          byte_cnt <= '0;
`ifdef CONV_CFG_READBACK_EN
          err_q    <= 1'b0;
`endif
        end
        DRAIN: if (!frame_open && outstanding == '0) begin
          state       <= LOAD;
          cfg_ready_q <= 1'b1;
        end
        LOAD: if (cfg_fire) begin
          for (int k = 0; k < VECTOR_LEN; k++)
            if (byte_cnt == BYTE_BW'(k)) wr_data_q[8*k +: 8] <= bus.cfg_data_i;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt    <= '0;
            cfg_ready_q <= 1'b0;
            wr_en_q     <= 1'b1;
            state       <= WRITE;
          end else begin
            byte_cnt <= byte_cnt + BYTE_BW'(1);
          end
        end
        WRITE: begin
          wr_en_q <= 1'b0;
`ifdef CONV_CFG_READBACK_EN
          rd_en_q <= 1'b1;
          state   <= READ;
`endif
        end
`ifdef CONV_CFG_READBACK_EN
        READ: begin
          rd_en_q <= 1'b0;
          state   <= CHECK;
        end
        CHECK: if (bus.mem_rd_data_i != wr_data_q) err_q <= 1'b1;
`endif
        default: state <= IDLE;
      endcase

      if (step) begin
        if (addr_q == LAST_ADDR) begin
          addr_q <= '0;
          bank_q <= bank_q + 2'd1;
        end else begin
          addr_q <= addr_q + ADDR_BW'(1);
        end
        if (last_word) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end else begin
          cfg_ready_q <= 1'b1;
          state       <= LOAD;
        end
      end
    end
  end

  assign bus.cfg_ready_o   = cfg_ready_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.mem_wr_en_o   = wr_en_q;
  assign bus.mem_bank_o    = bank_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_wr_data_o = wr_data_q;
endmodule
